// File: rtl/adc_axis_framer_if.sv
// AXI4-Stream bundle used on both sides of the framer: 16-bit sample-pair input and 32-bit framed output.
interface adc_axis_framer_if #(
    parameter int DATA_W = 16
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/adc_axis_framer.sv
// Frames AD9481 sample-pair packets into 32-bit packets (header, packed payload, trailer).
// Two data beats share one output word; null beats are dropped; runaway packets are cut at MAX_BEATS.
module adc_axis_framer #(
    parameter logic [15:0] FRAME_MAGIC = 16'hAD94,
    parameter int unsigned MAX_BEATS   = 1024
) (
    input  logic               axis_aclk,
    input  logic               axis_aresetn,
    adc_axis_framer_if.slave   s_axis,
    adc_axis_framer_if.master  m_axis,
    output logic [15:0]        frame_seq,
    output logic               trunc_seen
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;

    localparam logic [15:0] MAX_COUNT = 16'(MAX_BEATS);

    state_t      state;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [15:0] seq;
    logic [15:0] count;
    logic [15:0] half;
    logic        half_full;
    logic        trunc;

    logic        out_free;
    logic        in_fire;
    logic        is_data;
    logic [15:0] next_count;
    logic        hit_max;
    logic        frame_end;

    assign out_free      = !out_valid || m_axis.tready;
    assign s_axis.tready = (state == PAYLOAD) && out_free;
    assign in_fire       = s_axis.tvalid && s_axis.tready;
    assign is_data       = |s_axis.tkeep;
    assign next_count    = count + {15'd0, is_data};
    assign hit_max       = is_data && (next_count == MAX_COUNT);
    assign frame_end     = s_axis.tlast || hit_max;

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tlast  = out_last;
    assign frame_seq     = seq;

    // Every output load happens only when the output register is free, so a stalled word never changes.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            seq        <= '0;
            count      <= '0;
            half       <= '0;
            half_full  <= 1'b0;
            trunc      <= 1'b0;
            trunc_seen <= 1'b0;
        end else begin
            if (out_free) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (s_axis.tvalid && out_free) begin
                        out_valid <= 1'b1;
                        out_data  <= {FRAME_MAGIC, seq};
                        out_keep  <= 4'hF;
                        out_last  <= 1'b0;
                        state     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (in_fire) begin
                        count <= next_count;
                        if (is_data && half_full) begin
                            out_valid <= 1'b1;
                            out_data  <= {s_axis.tdata, half};
                            out_keep  <= 4'hF;
                            out_last  <= 1'b0;
                            half_full <= 1'b0;
                        end else if (frame_end && (half_full || is_data)) begin
                            // A lone sample at the end of a frame goes out as a half word.
                            out_valid <= 1'b1;
                            out_data  <= {16'h0, (is_data ? s_axis.tdata : half)};
                            out_keep  <= 4'h3;
                            out_last  <= 1'b0;
                            half_full <= 1'b0;
                        end else if (is_data) begin
                            half      <= s_axis.tdata;
                            half_full <= 1'b1;
                        end
                        if (frame_end) begin
                            state <= TRAILER;
                            if (!s_axis.tlast) begin
                                trunc      <= 1'b1;
                                trunc_seen <= 1'b1;
                            end
                        end
                    end
                end
                TRAILER: begin
                    if (out_free) begin
                        out_valid <= 1'b1;
                        out_data  <= {trunc, count[14:0], seq};
                        out_keep  <= 4'hF;
                        out_last  <= 1'b1;
                        seq       <= seq + 16'd1;
                        count     <= '0;
                        trunc     <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_axis_framer.sv
// Self-checking bench for adc_axis_framer: directed frames plus randomized traffic against a frame-level model.
module tb_adc_axis_framer;
    localparam int MAX_BEATS = 8;
    localparam int BUDGET    = 30000;

    typedef logic [36:0] word_t;
    typedef struct {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
    } beat_t;

    logic        axis_aclk;
    logic        axis_aresetn;
    logic [15:0] frame_seq;
    logic        trunc_seen;

    adc_axis_framer_if #(.DATA_W(16)) s_if ();
    adc_axis_framer_if #(.DATA_W(32)) m_if ();

    adc_axis_framer #(.FRAME_MAGIC(16'hAD94), .MAX_BEATS(MAX_BEATS)) dut (
        .axis_aclk    (axis_aclk),
        .axis_aresetn (axis_aresetn),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .frame_seq    (frame_seq),
        .trunc_seen   (trunc_seen)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    int          n_cmp = 0;
    int          n_fail = 0;
    beat_t       in_q[$];
    word_t       exp_q[$];
    word_t       obs_q[$];
    logic [15:0] model_seq = 16'h0;
    bit          model_trunc_seen = 1'b0;

    function automatic word_t w(input logic [31:0] d, input logic [3:0] k, input logic l);
        return {l, k, d};
    endfunction

    function automatic void add_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        in_q.push_back(b);
    endfunction

    // Frame-level model: gather each frame's data samples, then emit header, pairs, odd half and trailer.
    function automatic void model_stream();
        logic [15:0] pay[$];
        bit          open;
        bit          tr;
        open = 1'b0;
        foreach (in_q[i]) begin
            if (!open) begin
                exp_q.push_back(w({16'hAD94, model_seq}, 4'hF, 1'b0));
                open = 1'b1;
                pay.delete();
            end
            if (in_q[i].keep != 2'b00) pay.push_back(in_q[i].data);
            if (in_q[i].last || pay.size() == MAX_BEATS) begin
                for (int j = 0; j + 1 < pay.size(); j += 2)
                    exp_q.push_back(w({pay[j+1], pay[j]}, 4'hF, 1'b0));
                if (pay.size() % 2 == 1)
                    exp_q.push_back(w({16'h0, pay[pay.size()-1]}, 4'h3, 1'b0));
                tr = !in_q[i].last;
                if (tr) model_trunc_seen = 1'b1;
                exp_q.push_back(w({tr, 15'(pay.size()), model_seq}, 4'hF, 1'b1));
                model_seq = model_seq + 16'd1;
                open = 1'b0;
            end
        end
    endfunction

    // Streams in_q into the DUT and records every accepted output word; also counts stall-stability violations.
    task automatic applyStimulus(input int valid_pct, input int ready_pct, input int n_out,
                                 output int stall_errs, output bit timed_out);
        int    idx;
        int    cycles;
        bit    stalled;
        word_t held;
        word_t cur;
        idx = 0;
        cycles = 0;
        stalled = 1'b0;
        held = '0;
        stall_errs = 0;
        obs_q.delete();
        while ((idx < in_q.size() || obs_q.size() < n_out) && cycles < BUDGET) begin
            @(negedge axis_aclk);
            cycles++;
            if (idx < in_q.size() && $urandom_range(99) < valid_pct) begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = in_q[idx].data;
                s_if.tkeep  = in_q[idx].keep;
                s_if.tlast  = in_q[idx].last;
            end else begin
                s_if.tvalid = 1'b0;
                s_if.tdata  = 16'($urandom);
                s_if.tkeep  = 2'($urandom);
                s_if.tlast  = 1'($urandom);
            end
            m_if.tready = ($urandom_range(99) < ready_pct);
            #1;
            cur = {m_if.tlast, m_if.tkeep, m_if.tdata};
            if (stalled && cur !== held) stall_errs++;
            stalled = m_if.tvalid && !m_if.tready;
            held = cur;
            if (m_if.tvalid && m_if.tready) obs_q.push_back(cur);
            if (s_if.tvalid && s_if.tready) idx++;
        end
        timed_out = (cycles >= BUDGET);
        @(negedge axis_aclk);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (8) begin
            #1;
            if (m_if.tvalid) obs_q.push_back({m_if.tlast, m_if.tkeep, m_if.tdata});
            @(negedge axis_aclk);
        end
    endtask

    task automatic test_reset();
        axis_aresetn = 1'b0;
        #3;
        n_cmp++;
        if ({m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, s_if.tready} !== 39'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got tvalid=%b tdata=%h tkeep=%h tlast=%b s_tready=%b, expected all 0",
                     m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, s_if.tready);
        end
        n_cmp++;
        if ({frame_seq, trunc_seen} !== 17'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_status: got seq=%h trunc_seen=%b, expected 0/0", frame_seq, trunc_seen);
        end
        repeat (2) @(negedge axis_aclk);
        axis_aresetn = 1'b1;
        repeat (3) @(negedge axis_aclk);
        n_cmp++;
        if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_quiet: got m_tvalid=%b s_tready=%b, expected 0/0", m_if.tvalid, s_if.tready);
        end
    endtask

    task automatic test_basic_frame();
        int    se;
        bit    to;
        word_t got;
        in_q.delete(); exp_q.delete();
        add_beat(16'h0102, 2'h3, 1'b0);
        add_beat(16'h0304, 2'h3, 1'b0);
        add_beat(16'h0506, 2'h3, 1'b0);
        add_beat(16'h0708, 2'h3, 1'b1);
        exp_q.push_back(w(32'hAD940000, 4'hF, 1'b0));
        exp_q.push_back(w(32'h03040102, 4'hF, 1'b0));
        exp_q.push_back(w(32'h07080506, 4'hF, 1'b0));
        exp_q.push_back(w(32'h00040000, 4'hF, 1'b1));
        model_seq = 16'd1;
        applyStimulus(100, 100, exp_q.size(), se, to);
        n_cmp++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL basic_words: got %0d words (timeout=%0b), expected %0d", obs_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL basic_word%0d: got %h, expected %h", i, got, exp_q[i]);
            end
        end
        n_cmp++;
        if (frame_seq !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL basic_seq: got %h, expected 0001", frame_seq);
        end
    endtask

    task automatic test_odd_frame();
        int    se;
        bit    to;
        word_t got;
        in_q.delete(); exp_q.delete();
        add_beat(16'h0A0B, 2'h3, 1'b0);
        add_beat(16'h0C0D, 2'h3, 1'b0);
        add_beat(16'h0E0F, 2'h3, 1'b1);
        exp_q.push_back(w(32'hAD940001, 4'hF, 1'b0));
        exp_q.push_back(w(32'h0C0D0A0B, 4'hF, 1'b0));
        exp_q.push_back(w(32'h00000E0F, 4'h3, 1'b0));
        exp_q.push_back(w(32'h00030001, 4'hF, 1'b1));
        model_seq = 16'd2;
        applyStimulus(100, 100, exp_q.size(), se, to);
        n_cmp++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL odd_words: got %0d words (timeout=%0b), expected %0d", obs_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL odd_word%0d: got %h, expected %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_null_beats();
        int    se;
        bit    to;
        word_t got;
        in_q.delete(); exp_q.delete();
        add_beat(16'h1111, 2'h3, 1'b0);
        add_beat(16'hDEAD, 2'h0, 1'b0);
        add_beat(16'h2222, 2'h1, 1'b0);
        add_beat(16'hBEEF, 2'h0, 1'b0);
        add_beat(16'hCAFE, 2'h0, 1'b0);
        add_beat(16'h3333, 2'h2, 1'b0);
        add_beat(16'hF00D, 2'h0, 1'b1);
        add_beat(16'h4444, 2'h0, 1'b1);
        model_stream();
        applyStimulus(100, 60, exp_q.size(), se, to);
        n_cmp++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL null_words: got %0d words (timeout=%0b), expected %0d", obs_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL null_word%0d: got %h, expected %h", i, got, exp_q[i]);
            end
        end
        n_cmp++;
        if (trunc_seen !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL null_trunc_seen: got %b, expected 0", trunc_seen);
        end
    endtask

    task automatic test_truncation();
        int    se;
        bit    to;
        word_t got;
        in_q.delete(); exp_q.delete();
        for (int k = 1; k <= 10; k++) add_beat(16'h1000 + 16'(k), 2'h3, (k == 10));
        exp_q.push_back(w(32'hAD940004, 4'hF, 1'b0));
        exp_q.push_back(w(32'h10021001, 4'hF, 1'b0));
        exp_q.push_back(w(32'h10041003, 4'hF, 1'b0));
        exp_q.push_back(w(32'h10061005, 4'hF, 1'b0));
        exp_q.push_back(w(32'h10081007, 4'hF, 1'b0));
        exp_q.push_back(w(32'h80080004, 4'hF, 1'b1));
        exp_q.push_back(w(32'hAD940005, 4'hF, 1'b0));
        exp_q.push_back(w(32'h100A1009, 4'hF, 1'b0));
        exp_q.push_back(w(32'h00020005, 4'hF, 1'b1));
        model_seq = 16'd6;
        model_trunc_seen = 1'b1;
        applyStimulus(100, 100, exp_q.size(), se, to);
        n_cmp++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL trunc_words: got %0d words (timeout=%0b), expected %0d", obs_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL trunc_word%0d: got %h, expected %h", i, got, exp_q[i]);
            end
        end
        n_cmp++;
        if (trunc_seen !== 1'b1 || frame_seq !== 16'd6) begin
            n_fail++;
            $display("[TB] FAIL trunc_status: got trunc_seen=%b seq=%h, expected 1/0006", trunc_seen, frame_seq);
        end
    endtask

    task automatic test_random_backpressure();
        int    se;
        bit    to;
        int    len;
        word_t got;
        in_q.delete(); exp_q.delete();
        for (int f = 0; f < 200; f++) begin
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++)
                add_beat(16'($urandom), ($urandom_range(99) < 20) ? 2'h0 : 2'($urandom_range(1, 3)), (k == len - 1));
        end
        model_stream();
        applyStimulus(80, 30, exp_q.size(), se, to);
        n_cmp++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL rand_words: got %0d words (timeout=%0b), expected %0d", obs_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL rand_word%0d: got %h, expected %h", i, got, exp_q[i]);
            end
        end
        n_cmp++;
        if (se != 0) begin
            n_fail++;
            $display("[TB] FAIL rand_stall_stable: got %0d changes while stalled, expected 0", se);
        end
        n_cmp++;
        if (frame_seq !== model_seq || trunc_seen !== model_trunc_seen) begin
            n_fail++;
            $display("[TB] FAIL rand_status: got seq=%h trunc_seen=%b, expected %h/%b",
                     frame_seq, trunc_seen, model_seq, model_trunc_seen);
        end
    endtask

    task automatic test_reset_mid_frame();
        int    se;
        bit    to;
        word_t got;
        @(negedge axis_aclk);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 16'h5555;
        s_if.tkeep  = 2'h3;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        repeat (4) @(negedge axis_aclk);
        #2;
        axis_aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, s_if.tready} !== 39'h0) begin
            n_fail++;
            $display("[TB] FAIL midreset_outputs: got tvalid=%b tdata=%h tkeep=%h tlast=%b s_tready=%b, expected all 0",
                     m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, s_if.tready);
        end
        n_cmp++;
        if ({frame_seq, trunc_seen} !== 17'h0) begin
            n_fail++;
            $display("[TB] FAIL midreset_status: got seq=%h trunc_seen=%b, expected 0/0", frame_seq, trunc_seen);
        end
        s_if.tvalid = 1'b0;
        @(negedge axis_aclk);
        axis_aresetn = 1'b1;
        model_seq = 16'h0;
        model_trunc_seen = 1'b0;
        in_q.delete(); exp_q.delete();
        add_beat(16'h0A01, 2'h3, 1'b0);
        add_beat(16'h0A02, 2'h3, 1'b0);
        add_beat(16'h0A03, 2'h3, 1'b1);
        model_stream();
        applyStimulus(100, 100, exp_q.size(), se, to);
        n_cmp++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL midreset_words: got %0d words (timeout=%0b), expected %0d", obs_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL midreset_word%0d: got %h, expected %h", i, got, exp_q[i]);
            end
        end
    endtask

    initial begin
        axis_aresetn = 1'b0;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = '0;
        s_if.tkeep   = '0;
        s_if.tlast   = 1'b0;
        m_if.tready  = 1'b0;
        test_reset();
        test_basic_frame();
        test_odd_frame();
        model_seq = 16'd2;
        test_null_beats();
        test_truncation();
        test_random_backpressure();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
